// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings, state type, flag bundle and the signed-overflow
// rule for the alu_seq slice.
package alu_pkg;

  // Arithmetic set (l = 0)
  localparam logic [1:0] OP_NEG_A = 2'b00;
  localparam logic [1:0] OP_NEG_B = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_SUB   = 2'b11;

  // Logic set (l = 1)
  localparam logic [1:0] OP_AND   = 2'b00;
  localparam logic [1:0] OP_OR    = 2'b01;
  localparam logic [1:0] OP_XOR   = 2'b10;
  localparam logic [1:0] OP_NOT   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic sign;
    logic overflow;
  } flags_t;

  localparam flags_t FLAGS_RST = '{zero: 1'b1, carry: 1'b0, sign: 1'b0, overflow: 1'b0};

  // Two same-signed adder inputs giving a result of the other sign
  function automatic logic signed_ovf(input logic x_msb, input logic y_msb, input logic r_msb);
    return (x_msb == y_msb) && (r_msb != x_msb);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between the operand source (master) and
// alu_seq (slave).
//   master drives: start, ALUOp, l, mul, use_acc, A, B
//   slave drives : R, R_hi, zero, carry, sign, overflow, busy, done
interface alu_seq_if #(parameter int unsigned WIDTH = 8);
  logic             start;
  logic [1:0]       ALUOp;
  logic             l;
  logic             mul;
  logic             use_acc;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] R_hi;
  logic             zero;
  logic             carry;
  logic             sign;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, ALUOp, l, mul, use_acc, A, B,
    input  R, R_hi, zero, carry, sign, overflow, busy, done
  );

  modport slave (
    input  start, ALUOp, l, mul, use_acc, A, B,
    output R, R_hi, zero, carry, sign, overflow, busy, done
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit adder / logic unit.
//   op, l    : operation select (l = 1 picks the logic set)
//   a, b     : operands (a already substituted by the accumulator if needed)
//   result   : WIDTH-bit result
//   carry    : adder carry-out (0 for logic ops)
//   overflow : signed overflow of the adder (0 for logic ops)
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic             l,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] x_c;
  logic [WIDTH-1:0] y_c;
  logic             cin_c;
  logic [WIDTH:0]   sum_c;

  // Adder operand selection: negation and subtraction use complement + carry-in
  always_comb begin
    x_c   = '0;
    y_c   = '0;
    cin_c = 1'b0;
    case (op)
      OP_NEG_A: begin x_c = '0; y_c = ~a; cin_c = 1'b1; end
      OP_NEG_B: begin x_c = '0; y_c = ~b; cin_c = 1'b1; end
      OP_ADD:   begin x_c = a;  y_c = b;  cin_c = 1'b0; end
      default:  begin x_c = a;  y_c = ~b; cin_c = 1'b1; end
    endcase
    sum_c = {1'b0, x_c} + {1'b0, y_c} + (WIDTH+1)'(cin_c);
  end

  // Result and flag mux
  always_comb begin
    result   = sum_c[WIDTH-1:0];
    carry    = sum_c[WIDTH];
    overflow = signed_ovf(x_c[WIDTH-1], y_c[WIDTH-1], sum_c[WIDTH-1]);
    if (l) begin
      carry    = 1'b0;
      overflow = 1'b0;
      case (op)
        OP_AND:  result = a & b;
        OP_OR:   result = a | b;
        OP_XOR:  result = a ^ b;
        default: result = ~a;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked WIDTH-bit ALU with registered result/flags, start/done
// handshake and accumulator feedback (use_acc selects R as operand A).
//   clk, reset : clock, synchronous active-high reset
//   bus        : alu_seq_if slave (operands in, R/R_hi/flags/busy/done out)
// Macro ALU_MUL_EN builds the multi-cycle shift-add unsigned multiplier
// (MUL state, step counter, R_hi register); without it busy and R_hi are 0.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  logic [WIDTH-1:0] r_q;
  flags_t           flags_q;
  logic             done_q;

  logic [WIDTH-1:0] a_sel_c;
  logic [WIDTH-1:0] core_res_c;
  logic             core_carry_c;
  logic             core_ovf_c;
  flags_t           alu_flags_c;

  assign a_sel_c = bus.use_acc ? r_q : bus.A;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op       (bus.ALUOp),
    .l        (bus.l),
    .a        (a_sel_c),
    .b        (bus.B),
    .result   (core_res_c),
    .carry    (core_carry_c),
    .overflow (core_ovf_c)
  );

  assign alu_flags_c = '{zero:     (core_res_c == '0),
                         carry:    core_carry_c,
                         sign:     core_res_c[WIDTH-1],
                         overflow: core_ovf_c};

  assign bus.R        = r_q;
  assign bus.zero     = flags_q.zero;
  assign bus.carry    = flags_q.carry;
  assign bus.sign     = flags_q.sign;
  assign bus.overflow = flags_q.overflow;
  assign bus.done     = done_q;

`ifdef ALU_MUL_EN
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   r_hi_q;
  logic               busy_q;

  logic               accept_alu_c, accept_mul_c, step_c, finish_c;
  logic [WIDTH:0]     add_c;
  logic [2*WIDTH-1:0] prod_next_c;
  flags_t             mul_flags_c;

  // Next-state and control decode
  always_comb begin
    state_d      = state_q;
    accept_alu_c = 1'b0;
    accept_mul_c = 1'b0;
    step_c       = 1'b0;
    finish_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.mul) begin
            accept_mul_c = 1'b1;
            state_d      = ST_MUL;
          end else begin
            accept_alu_c = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == CW'(WIDTH)) begin
          finish_c = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          step_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One shift-add step: conditionally add multiplicand into the high half, shift right
  assign add_c       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_next_c = {add_c, prod_q[WIDTH-1:1]};

  assign mul_flags_c = '{zero:     (prod_q == '0),
                         carry:    (prod_q[2*WIDTH-1:WIDTH] != '0),
                         sign:     prod_q[2*WIDTH-1],
                         overflow: 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      r_q     <= '0;
      r_hi_q  <= '0;
      flags_q <= FLAGS_RST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept_alu_c) begin
        r_q     <= core_res_c;
        r_hi_q  <= '0;
        flags_q <= alu_flags_c;
        done_q  <= 1'b1;
      end
      if (accept_mul_c) begin
        mcand_q <= a_sel_c;
        prod_q  <= {{WIDTH{1'b0}}, bus.B};
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end
      if (step_c) begin
        prod_q <= prod_next_c;
        cnt_q  <= cnt_q + CW'(1);
      end
      if (finish_c) begin
        r_q     <= prod_q[WIDTH-1:0];
        r_hi_q  <= prod_q[2*WIDTH-1:WIDTH];
        flags_q <= mul_flags_c;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.R_hi = r_hi_q;
`else
  // Multiply request has no meaning in this build
  logic unused_mul;
  assign unused_mul = bus.mul;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= '0;
      flags_q <= FLAGS_RST;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        r_q     <= core_res_c;
        flags_q <= alu_flags_c;
        done_q  <= 1'b1;
      end
    end
  end

  assign bus.busy = 1'b0;
  assign bus.R_hi = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH = 8).
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge, then sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] op, input logic lg, input logic [7:0] a, input logic [7:0] b);
    bus.start   = 1'b1;
    bus.ALUOp   = op;
    bus.l       = lg;
    bus.mul     = 1'b0;
    bus.use_acc = 1'b0;
    bus.A       = a;
    bus.B       = b;
  endtask

  initial begin
    int dones;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.ALUOp   = 2'b00;
    bus.l       = 1'b0;
    bus.mul     = 1'b0;
    bus.use_acc = 1'b0;
    bus.A       = 8'h00;
    bus.B       = 8'h00;

    // Reset state
    tick(); tick();
    chk("rst_R", 16'(bus.R), 16'h00);
    chk("rst_R_hi", 16'(bus.R_hi), 16'h00);
    chk("rst_zero", 16'(bus.zero), 16'h1);
    chk("rst_carry", 16'(bus.carry), 16'h0);
    chk("rst_sign", 16'(bus.sign), 16'h0);
    chk("rst_ovf", 16'(bus.overflow), 16'h0);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_done", 16'(bus.done), 16'h0);
    reset = 1'b0;

    // ADD F0 + 20 = 110
    req(OP_ADD, 1'b0, 8'hF0, 8'h20);
    tick();
    bus.start = 1'b0;
    chk("add_done", 16'(bus.done), 16'h1);
    chk("add_R", 16'(bus.R), 16'h10);
    chk("add_carry", 16'(bus.carry), 16'h1);
    chk("add_ovf", 16'(bus.overflow), 16'h0);
    chk("add_sign", 16'(bus.sign), 16'h0);
    chk("add_zero", 16'(bus.zero), 16'h0);
    tick();
    chk("add_done_pulse", 16'(bus.done), 16'h0);
    chk("add_hold_R", 16'(bus.R), 16'h10);

    // SUB 80 - 01 = 7F with signed overflow, then back-to-back NEG A of 0
    req(OP_SUB, 1'b0, 8'h80, 8'h01);
    tick();
    chk("sub_R", 16'(bus.R), 16'h7F);
    chk("sub_carry", 16'(bus.carry), 16'h1);
    chk("sub_ovf", 16'(bus.overflow), 16'h1);
    chk("sub_sign", 16'(bus.sign), 16'h0);
    req(OP_NEG_A, 1'b0, 8'h00, 8'h01);
    tick();
    bus.start = 1'b0;
    chk("nega_done_b2b", 16'(bus.done), 16'h1);
    chk("nega_R", 16'(bus.R), 16'h00);
    chk("nega_zero", 16'(bus.zero), 16'h1);
    chk("nega_carry", 16'(bus.carry), 16'h1);

    // NEG B of 0x80: 0 + 7F + 1 = 80, overflow
    req(OP_NEG_B, 1'b0, 8'h11, 8'h80);
    tick();
    chk("negb_R", 16'(bus.R), 16'h80);
    chk("negb_ovf", 16'(bus.overflow), 16'h1);
    chk("negb_carry", 16'(bus.carry), 16'h0);
    chk("negb_sign", 16'(bus.sign), 16'h1);

    // Logic ops
    req(OP_XOR, 1'b1, 8'hAA, 8'hAA);
    tick();
    chk("xor_R", 16'(bus.R), 16'h00);
    chk("xor_zero", 16'(bus.zero), 16'h1);
    chk("xor_carry", 16'(bus.carry), 16'h0);
    chk("xor_ovf", 16'(bus.overflow), 16'h0);
    // Accumulator feedback: R(0) + 5, then R(5) + 5; port A must be ignored
    req(OP_ADD, 1'b0, 8'h77, 8'h05);
    bus.use_acc = 1'b1;
    tick();
    chk("acc1_R", 16'(bus.R), 16'h05);
    req(OP_ADD, 1'b0, 8'h77, 8'h05);
    bus.use_acc = 1'b1;
    tick();
    chk("acc2_R", 16'(bus.R), 16'h0A);
    req(OP_AND, 1'b1, 8'hF0, 8'h3C);
    tick();
    chk("and_R", 16'(bus.R), 16'h30);
    req(OP_OR, 1'b1, 8'hF0, 8'h3C);
    tick();
    chk("or_R", 16'(bus.R), 16'hFC);
    chk("or_sign", 16'(bus.sign), 16'h1);
    req(OP_NOT, 1'b1, 8'h0F, 8'h00);
    tick();
    chk("not_R", 16'(bus.R), 16'hF0);
    chk("not_R_hi", 16'(bus.R_hi), 16'h00);
    bus.start = 1'b0;
    tick(); tick();
    chk("idle_done", 16'(bus.done), 16'h0);
    chk("idle_hold_R", 16'(bus.R), 16'hF0);

`ifdef ALU_MUL_EN
    // FF * FF = FE01, busy for 9 cycles, start while busy ignored
    req(OP_ADD, 1'b0, 8'hFF, 8'hFF);
    bus.mul = 1'b1;
    tick();
    bus.mul = 1'b0;
    bus.A   = 8'h01;
    bus.B   = 8'h01;
    chk("mul_busy0", 16'(bus.busy), 16'h1);
    chk("mul_nodone0", 16'(bus.done), 16'h0);
    chk("mul_hide_R", 16'(bus.R), 16'hF0);
    for (int i = 1; i < 9; i++) begin
      tick();
      bus.start = (i == 2 || i == 3);
      chk("mul_busy", 16'(bus.busy), 16'h1);
      chk("mul_nodone", 16'(bus.done), 16'h0);
    end
    tick();
    chk("mul_done", 16'(bus.done), 16'h1);
    chk("mul_busy_end", 16'(bus.busy), 16'h0);
    chk("mul_R_hi", 16'(bus.R_hi), 16'hFE);
    chk("mul_R", 16'(bus.R), 16'h01);
    chk("mul_carry", 16'(bus.carry), 16'h1);
    chk("mul_zero", 16'(bus.zero), 16'h0);
    chk("mul_sign", 16'(bus.sign), 16'h1);
    chk("mul_ovf", 16'(bus.overflow), 16'h0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) dones++;
    end
    chk("mul_single_done", 16'(dones), 16'h0);
    chk("mul_hold_R", 16'(bus.R), 16'h01);

    // 0F * 03 = 002D completes normally
    req(OP_ADD, 1'b1, 8'h0F, 8'h03);
    bus.mul = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mul2_done", 16'(bus.done), 16'h1);
    chk("mul2_R", 16'(bus.R), 16'h2D);
    chk("mul2_R_hi", 16'(bus.R_hi), 16'h00);
    chk("mul2_carry", 16'(bus.carry), 16'h0);

    // Same multiply aborted by reset 4 cycles after start
    req(OP_ADD, 1'b0, 8'h0F, 8'h03);
    bus.mul = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 16'(bus.busy), 16'h0);
    chk("abort_R", 16'(bus.R), 16'h00);
    chk("abort_R_hi", 16'(bus.R_hi), 16'h00);
    chk("abort_zero", 16'(bus.zero), 16'h1);
    chk("abort_done", 16'(bus.done), 16'h0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) dones++;
    end
    chk("abort_no_done", 16'(dones), 16'h0);
`else
    // mul ignored: decoded as single-cycle ADD
    req(OP_ADD, 1'b0, 8'h02, 8'h03);
    bus.mul = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("nomul_done", 16'(bus.done), 16'h1);
    chk("nomul_R", 16'(bus.R), 16'h05);
    chk("nomul_R_hi", 16'(bus.R_hi), 16'h00);
    chk("nomul_busy", 16'(bus.busy), 16'h0);
    tick();
    chk("nomul_done_pulse", 16'(bus.done), 16'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the 4-bit combinational ALU: a WIDTH-bit ALU with registered result and flags, a start/done handshake and an accumulator feedback path. An optional multi-cycle shift-add unsigned multiplier can be compiled in. It sits between the register file / operand latches and the datapath result bus of the teaching CPU.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2).
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- ALUOp  in  2  operation select.
- l  in  1  0 = arithmetic, 1 = logic.
- mul  in  1  1 = multiply request; ignored unless ALU_MUL_EN is defined.
- use_acc  in  1  1 = operand A is taken from the current R register instead of port A.
- A, B  in  WIDTH  operands, unsigned or two's complement.
- R  out  WIDTH  registered result (low half of the product for multiply).
- R_hi  out  WIDTH  registered high half of the product; 0 otherwise.
- zero, carry, sign, overflow  out  1  registered flags.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse; results are valid from this cycle on.

## Operation
- States are IDLE and MUL. MUL exists only with ALU_MUL_EN.
- IDLE, start=1, and no active multiply: operands are captured and one operation is executed.
- Arithmetic, l=0:
  - 00: R = −A, computed as 0 + ~A + 1.
  - 01: R = −B.
  - 10: R = A + B.
  - 11: R = A − B, computed as A + ~B + 1.
- Arithmetic flags:
  - carry = adder carry-out. For subtraction, 1 means no borrow.
  - overflow = signed overflow of the adder.
  - sign = R[WIDTH−1].
  - zero = (R == 0).
- Logic, l=1:
  - 00: A & B.
  - 01: A | B.
  - 10: A ^ B.
  - 11: ~A.
- Logic flags: carry = 0, overflow = 0, sign = R[WIDTH−1], zero = (R == 0). All flags are defined values, never x.
- use_acc=1 substitutes the R value held at the start edge for A, in every operation.
- Multiply (mul=1, l ignored): {R_hi, R} = A × B, unsigned, using a shift-add algorithm with one partial step per clock.
- Multiply flags:
  - zero = full 2·WIDTH-bit product is 0.
  - carry = (R_hi != 0).
  - sign = R_hi[WIDTH−1].
  - overflow = 0.
- Single-cycle operations write R_hi = 0.
- Outputs hold their values until the next done. Internal partial products never appear on R or R_hi.

## Timing
- Reset values: R = 0, R_hi = 0, zero = 1, carry = 0, sign = 0, overflow = 0, busy = 0, done = 0, state = IDLE.
- Single-cycle operation: start is sampled at edge k. R, R_hi and flags update at edge k, and done=1 for the cycle after edge k. Latency is 1. Back-to-back starts are accepted every cycle.
- Multiply: start is sampled at edge k. busy=1 from edge k. Steps run at edges k+1 … k+WIDTH. Results, done=1 and busy=0 appear at edge k+WIDTH+1. Latency is WIDTH+1.
- start while busy=1 is ignored: not queued, and produces no done.
- A new start is accepted in the same cycle in which done is high.
- reset asserted mid-multiply aborts it. All outputs take their reset values at that edge, and no done is produced.
- A, B, ALUOp, l, mul and use_acc are needed only at the start edge. Changes while busy have no effect.

## Configuration
- ALU_MUL_EN defined: the MUL state, step counter, shift-add datapath and R_hi register are built.
- ALU_MUL_EN undefined:
  - mul is ignored, and the operation is decoded from l/ALUOp as single-cycle.
  - busy is tied to 0 and R_hi is tied to 0.
  - Every accepted start completes in 1 cycle.

## Structure
- Package alu_pkg holds:
  - ALUOp encodings for the arithmetic and logic sets.
  - The state encoding (IDLE, MUL).
  - A function for the signed-overflow rule.
- Sub-module alu_core: purely combinational WIDTH-bit adder and logic unit, with the operand selection and complement above. Outputs are result, carry-out and overflow.
- alu_seq holds the handshake, the state machine, the multiplier and all registers.

## Test plan
All scenarios use WIDTH=8.
1. Apply reset for 2 cycles → R=0x00, zero=1, carry=0, busy=0, done=0.
2. start, l=0, ALUOp=10, A=0xF0, B=0x20 → next cycle done=1, R=0x10, carry=1, overflow=0, sign=0, zero=0.
3. start, l=0, ALUOp=11, A=0x80, B=0x01 → R=0x7F, carry=1, overflow=1, sign=0. Then ALUOp=00, A=0x00 → R=0x00, zero=1, carry=1.
4. start, l=1, ALUOp=10, A=0xAA, B=0xAA → R=0x00, zero=1, carry=0, overflow=0. Then use_acc=1, l=0, ALUOp=10, B=0x05 → R=0x05.
5. With ALU_MUL_EN: start, mul=1, A=0xFF, B=0xFF → busy=1 for 9 cycles, then done=1 with R_hi=0xFE, R=0x01, carry=1, zero=0. A second start issued while busy → ignored, exactly one done.
6. With ALU_MUL_EN: multiply A=0x0F, B=0x03, with reset asserted 4 cycles after start → busy=0, R=0, zero=1, and no done pulse. Without ALU_MUL_EN: mul=1, l=0, ALUOp=10, A=0x02, B=0x03 → R=0x05 after 1 cycle, R_hi=0, busy=0.
